// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the registered stream multiplexer.
//   clog2        - ceiling log2, used to size channel indices (minimum 1 bit)
//   MODE_FIXED   - rr_en encoding selecting the fixed-select arbiter
//   MODE_RR      - rr_en encoding selecting round-robin arbitration
//   lock_state_e - packet lock state of the multiplexer
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // A single-channel index still needs one bit so port widths never collapse.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder.
//   req     in  N    - request vector
//   ptr     in  SELW - highest-priority index (must be < N)
//   gnt_idx out SELW - first requesting index searching ptr, ptr+1, ... with wrap
//   gnt_any out 1    - at least one request present
module rr_pick
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  localparam logic [SELW:0] NV = (SELW+1)'(N);

  logic [N-1:0] rot;
  logic [SELW:0] idx;

  always_comb begin
    // Rotating the doubled vector puts channel ptr at bit 0, so a plain
    // lowest-set-bit search implements the wrapped priority order.
    rot     = N'({req, req} >> ptr);
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        idx     = {1'b0, ptr} + (SELW+1)'(k);
      end
    end
    if (idx >= NV) idx = idx - NV;
    gnt_idx = idx[SELW-1:0];
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream multiplexer with valid/ready
// handshake, packet locking and fixed-select or round-robin arbitration.
//   clk       in  1       - rising-edge clock
//   rst_n     in  1       - synchronous active-low reset
//   rr_en     in  1       - MODE_RR: round-robin, MODE_FIXED: use sel
//   sel       in  SELW    - fixed-mode channel; values >= N grant nothing
//   in_data   in  N*WIDTH - channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  N       - per-channel valid
//   in_last   in  N       - per-channel end-of-packet
//   in_ready  out N       - per-channel ready, at most one bit set
//   out_data  out WIDTH   - registered data
//   out_ch    out SELW    - source channel of out_data
//   out_last  out 1       - registered end-of-packet
//   out_valid out 1       - registered valid
//   out_ready in  1       - consumer ready
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rr_en,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW:0] NV = (SELW+1)'(N);

  lock_state_e      state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;

  logic             ld;
  logic [SELW-1:0]  pick_idx;
  logic             pick_any;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic             accept;

  // The output register can take a beat when empty or being drained.
  assign ld = !out_valid_q || out_ready;

  rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Grant selection: a held lock overrides both arbitration modes.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (state_q == ST_LOCKED) begin
      gnt_idx = lock_ch_q;
      gnt_vld = 1'b1;
    end else if (rr_en == MODE_RR) begin
      gnt_idx = pick_idx;
      gnt_vld = pick_any;
    end else begin
      gnt_idx = sel;
      gnt_vld = ({1'b0, sel} < NV);
    end
  end

  // Ready goes to the granted channel even when it is not valid, so a locked
  // channel that stalls produces bubbles instead of yielding the output.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        in_ready[i] = rst_n && ld && gnt_vld;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        gnt_last    = in_last[i];
      end
    end
  end

  assign accept = |(in_ready & in_valid);

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_last_d  = gnt_last;
      out_valid_d = 1'b1;
      if (gnt_last) begin
        // Priority only rotates at packet boundaries.
        state_d = ST_UNLOCKED;
        ptr_d   = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = gnt_idx;
      end
    end else if (ld) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_UNLOCKED;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: bench for stream_mux_rr. A transaction-level model
// tracks lock, priority pointer and the output register from the stream
// rules; each scenario task compares the DUT against it and against
// scenario-specific constants.
module tb_stream_mux_rr;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               rr_en;
  logic [SELW-1:0]    sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Five-channel instance, so that out-of-range sel values exist.
  logic        rr_en5 = 1'b0;
  logic [2:0]  sel5 = 3'd0;
  logic [39:0] in_data5 = '0;
  logic [4:0]  in_valid5 = '0;
  logic [4:0]  in_last5 = '0;
  logic [4:0]  in_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_last5;
  logic        out_valid5;
  logic        out_ready5 = 1'b1;

  stream_mux_rr #(.WIDTH(8), .N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en5), .sel(sel5),
    .in_data(in_data5), .in_valid(in_valid5), .in_last(in_last5),
    .in_ready(in_ready5), .out_data(out_data5), .out_ch(out_ch5),
    .out_last(out_last5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  int checks = 0;
  int passed = 0;

  // Reference model state.
  bit               m_locked = 0;
  int               m_lch = 0;
  int               m_ptr = 0;
  logic             m_ov = 1'b0;
  logic [WIDTH-1:0] m_od = '0;
  logic [SELW-1:0]  m_och = '0;
  logic             m_ol = 1'b0;
  logic [N-1:0]     exp_rdy, seen_rdy;
  int               last_g;
  bit               last_acc;

  // Channel that may transfer this cycle, or -1 for none.
  function automatic int m_grant();
    if (m_locked) return m_lch;
    if (rr_en == 1'b0) return int'(sel);
    for (int k = 0; k < N; k++)
      if (in_valid[SELW'((m_ptr + k) % N)]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Samples ready before the edge, advances one clock, updates the model.
  // Returns 1 time unit after the edge, where the caller compares and drives.
  task automatic tick();
    int g;
    logic ld;
    #1;
    ld = !m_ov || out_ready;
    g = m_grant();
    exp_rdy = '0;
    if (rst_n && ld && g >= 0) exp_rdy = N'(1) << g;
    seen_rdy = in_ready;
    last_acc = 0;
    last_g = g;
    @(posedge clk);
    if (!rst_n) begin
      m_locked = 0; m_lch = 0; m_ptr = 0;
      m_ov = 1'b0; m_od = '0; m_och = '0; m_ol = 1'b0;
    end else if (ld) begin
      if (g >= 0 && in_valid[SELW'(g)]) begin
        last_acc = 1;
        m_ov  = 1'b1;
        m_od  = WIDTH'(in_data >> (g * WIDTH));
        m_och = SELW'(g);
        m_ol  = in_last[SELW'(g)];
        if (m_ol) begin
          m_locked = 0;
          m_ptr = (g + 1) % N;
        end else begin
          m_locked = 1;
          m_lch = g;
        end
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
  endtask

  task automatic rand_data();
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rr_en = 1'b1; sel = 2'd0; out_ready = 1'b1;
    in_valid = '1; in_last = '1; rand_data();
    tick();
    tick();
    if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== '0) begin
      $display("FAIL reset: rdy/vld/ch/last/data got %b/%b/%0d/%b/%h want all zero",
               seen_rdy, out_valid, out_ch, out_last, out_data);
    end else passed++;
    checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    logic [WIDTH-1:0] d2;
    do_reset();
    rr_en = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = '1; in_last = '1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      d2 = in_data[95:64];
      tick();
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL fixed_model[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
      if (seen_rdy !== 4'b0100 || out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== d2) begin
        $display("FAIL fixed_ch2[%0d]: rdy/vld/ch/data got %b/%b/%0d/%h want 0100/1/2/%h", i,
                 seen_rdy, out_valid, out_ch, out_data, d2);
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_rr();
    do_reset();
    rr_en = 1'b1; out_ready = 1'b1; in_valid = '1; in_last = '1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      tick();
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL rr_model[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(i % 4)) begin
        $display("FAIL rr_seq[%0d]: vld/ch got %b/%0d want 1/%0d", i, out_valid, out_ch, i % 4);
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_packet();
    int k1;
    int exp_ch[5] = '{0, 1, 1, 1, 2};
    do_reset();
    rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b0001; in_last = '1;
    k1 = 0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      if (i == 1) in_valid = 4'b0111;
      in_last = {2'b11, (k1 == 2), 1'b1};
      tick();
      if (last_acc && last_g == 1) k1++;
      if (k1 == 3) in_valid[1] = 1'b0;
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL packet_model[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(exp_ch[i])) begin
        $display("FAIL packet_seq[%0d]: vld/ch got %b/%0d want 1/%0d", i, out_valid, out_ch, exp_ch[i]);
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_backpressure();
    bit pat[10] = '{1, 0, 0, 0, 1, 1, 1, 0, 1, 1};
    logic [WIDTH-1:0] held;
    logic hv;
    do_reset();
    rr_en = 1'b1; in_valid = '1; in_last = '1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      out_ready = pat[i];
      held = out_data;
      hv = out_valid;
      tick();
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL bp_model[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
      if (!pat[i] && hv) begin
        if (seen_rdy !== 4'b0000 || out_valid !== 1'b1 || out_data !== held) begin
          $display("FAIL bp_hold[%0d]: rdy/vld/data got %b/%b/%h want 0000/1/%h", i,
                   seen_rdy, out_valid, out_data, held);
        end else passed++;
        checks++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_sel_change();
    int k1;
    int exp_ch[7] = '{1, 1, 1, 1, 3, 3, 3};
    do_reset();
    rr_en = 1'b0; sel = 2'd1; out_ready = 1'b1; in_valid = 4'b1010;
    k1 = 0;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      in_last = {1'b1, 1'b0, (k1 == 3), 1'b0};
      tick();
      if (last_acc && last_g == 1) k1++;
      if (k1 == 4) in_valid[1] = 1'b0;
      if (i == 1) sel = 2'd3;
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL selchg_model[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(exp_ch[i])) begin
        $display("FAIL selchg_seq[%0d]: vld/ch got %b/%0d want 1/%0d", i, out_valid, out_ch, exp_ch[i]);
      end else passed++;
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d3;
    do_reset();
    rr_en = 1'b1; out_ready = 1'b1; in_valid = 4'b0010; in_last = 4'b0000;
    rand_data();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== '0) begin
      $display("FAIL reset_mid: rdy/vld/ch/last/data got %b/%b/%0d/%b/%h want all zero",
               seen_rdy, out_valid, out_ch, out_last, out_data);
    end else passed++;
    checks++;
    rst_n = 1'b1;
    in_valid = 4'b1000; in_last = 4'b1000;
    rand_data();
    d3 = in_data[127:96];
    tick();
    if (seen_rdy !== 4'b1000 || out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== d3) begin
      $display("FAIL reset_regrant: rdy/vld/ch/data got %b/%b/%0d/%h want 1000/1/3/%h",
               seen_rdy, out_valid, out_ch, out_data, d3);
    end else passed++;
    checks++;
  endtask

  task automatic test_sel_oob();
    logic [7:0] d4;
    sel5 = 3'd6; in_valid5 = '1; in_last5 = '1; out_ready5 = 1'b1;
    in_data5 = {$urandom, 8'($urandom)};
    for (int i = 0; i < 3; i++) begin
      tick();
      if (in_ready5 !== 5'b0 || out_valid5 !== 1'b0) begin
        $display("FAIL sel_oob[%0d]: rdy/vld got %b/%b want 00000/0", i, in_ready5, out_valid5);
      end else passed++;
      checks++;
    end
    sel5 = 3'd4;
    d4 = in_data5[39:32];
    tick();
    if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== d4) begin
      $display("FAIL sel_top: vld/ch/data got %b/%0d/%h want 1/4/%h", out_valid5, out_ch5, out_data5, d4);
    end else passed++;
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 80) != 0);
      if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
      if ($urandom_range(0, 3) == 0) sel = SELW'($urandom);
      in_valid  = N'($urandom);
      in_last   = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
      if ({seen_rdy, out_valid, out_ch, out_last, out_data} !== {exp_rdy, m_ov, m_och, m_ol, m_od}) begin
        $display("FAIL random[%0d]: got %b/%b/%0d/%b/%h want %b/%b/%0d/%b/%h", i,
                 seen_rdy, out_valid, out_ch, out_last, out_data, exp_rdy, m_ov, m_och, m_ol, m_od);
      end else passed++;
      checks++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr();
    test_packet();
    test_backpressure();
    test_sel_change();
    test_reset_mid();
    test_sel_oob();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake, packet locking and selectable fixed-select or round-robin arbitration. It is the sequential successor to the 32-bit 4:1 combinational mux tree. It sits between multiple producer streams and a single consumer, such as a shared bus or write port.

## Interface
- `WIDTH`, 32, data bits per channel
- `N`, 4, number of input channels (2..16)
- `SELW`, clog2(N), width of channel index; derived, not overridden

- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `rr_en` in 1: 1 = round-robin arbitration, 0 = fixed select via `sel`
- `sel` in SELW: channel index for fixed mode; values ≥ N select nothing
- `in_data` in N*WIDTH: channel i at bits [i*WIDTH +: WIDTH]
- `in_valid` in N: per-channel valid
- `in_last` in N: per-channel end-of-packet flag
- `in_ready` out N: per-channel ready, at most one bit set (one-hot)
- `out_data` out WIDTH: registered data
- `out_ch` out SELW: source channel of `out_data`
- `out_last` out 1: registered end-of-packet
- `out_valid` out 1: registered valid
- `out_ready` in 1: consumer ready

## Operation
- Load enable: `ld = !out_valid || out_ready`. One beat transfers per cycle maximum.
- Grant selection (combinational, each cycle):
  - When locked, the grant is the locked channel.
  - Otherwise, fixed mode grants `sel` if `sel < N`, else no grant.
  - Otherwise, round-robin mode grants the first channel with `in_valid` set, searching from `ptr` upward with wrap (ptr, ptr+1, …, N-1, 0, …, ptr-1).
- `in_ready[g] = ld && grant valid`, including locked channels with `in_valid=0`. All other bits are 0. Accept occurs when `in_ready[g] && in_valid[g]`.
- On accept, the output register loads `in_data[g]`, `g`, `in_last[g]` and sets `out_valid=1`.
- If `ld` is true and no accept occurs, clear `out_valid`; `out_data`, `out_ch` and `out_last` hold their values.
- Packet lock states: UNLOCKED → LOCKED(g) on an accepted beat with `in_last=0`. LOCKED(g) → UNLOCKED on an accepted beat with `in_last=1`.
- While LOCKED, changes to `rr_en` and `sel` are ignored.
- `ptr` updates to (g+1) mod N on every accepted beat with `in_last=1`. It never moves mid-packet.
- Single-beat packets (`in_last=1` on the first beat) never lock.

## Timing
- Latency: 1 cycle from input accept to `out_valid`. Full throughput: 1 beat/cycle with `out_ready` held high.
- Reset values (sync, `rst_n=0` at a rising edge): `out_valid=0`, `out_data=0`, `out_ch=0`, `out_last=0`, `ptr=0`, state UNLOCKED. `in_ready` is all 0 during reset.
- Reset mid-packet discards the lock and the held beat. No beat is accepted on the reset edge.
- Backpressure: `out_ready=0` with `out_valid=1` forces all `in_ready=0`, and the output holds stable.
- Simultaneous events: consume and load in the same cycle is allowed (`ld` true via `out_ready`).
- Wrap-around: `ptr=N-1` with a last beat wraps to 0.
- `sel ≥ N` in fixed mode yields `in_ready=0` and no transfer.
- Locked channel stall: `in_valid=0` creates bubbles but no other channel is granted.

## Structure
- Shared package/header `mux_pkg`:
  - `clog2` function
  - `MODE_FIXED`/`MODE_RR` encodings of `rr_en`
- Sub-module `rr_pick` (N, SELW): rotating priority encoder. Inputs are `req[N]` and `ptr`; outputs are `gnt_idx` and `gnt_any`.
- Top level contains the lock FSM, `ptr` register and output register.

## Test plan
- Fixed mode, sel=2, all channels valid, single-beat packets, `out_ready=1` → only channel 2 accepted each cycle; `out_ch=2`; data appears 1 cycle later.
- RR mode, all 4 channels valid with single-beat packets → `out_ch` sequence 0,1,2,3,0; one beat per cycle.
- RR, ch1 sends 3-beat packet (last on beat 3) while ch0, ch2 valid → beats 1..3 all `out_ch=1` contiguously; next grant goes to ch2 and `ptr` becomes 2.
- `out_ready=0` for 3 cycles with `out_valid=1` → `out_data` is stable, `in_ready=0`, no loss or duplication after release.
- Fixed mode, sel changes 1→3 mid-packet on ch1 → remaining ch1 beats complete; ch3 is granted only after ch1 `last`.
- `rst_n=0` asserted mid-packet → next cycle all outputs are at reset values; a new packet from ch3 is granted immediately (unlocked, ptr=0 search).
